// File: rtl/bus_host_arbiter_if.sv
// Host-side and bus-side signal bundle for the host port arbiter.
interface bus_host_arbiter_if #(
  parameter int Hosts        = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [Hosts-1:0]                   h_req_in;
  logic [Hosts-1:0][AddressWidth-1:0] h_addr_in;
  logic [Hosts-1:0]                   h_we_in;
  logic [Hosts-1:0][DataWidth-1:0]    h_wdata_in;
  logic [Hosts-1:0]                   h_gnt_out;
  logic [Hosts-1:0][DataWidth-1:0]    h_rdata_out;
  logic [Hosts-1:0]                   h_rvalid_out;
  logic                               m_req_out;
  logic [AddressWidth-1:0]            m_addr_out;
  logic                               m_we_out;
  logic [DataWidth-1:0]               m_wdata_out;
  logic                               m_gnt_in;
  logic [DataWidth-1:0]               m_rdata_in;

  // Arbiter view: consumes host requests and bus responses, drives the bus and host returns.
  modport master (
    input  h_req_in, h_addr_in, h_we_in, h_wdata_in, m_gnt_in, m_rdata_in,
    output h_gnt_out, h_rdata_out, h_rvalid_out, m_req_out, m_addr_out, m_we_out, m_wdata_out
  );

  // Environment view: the hosts plus the downstream bus.
  modport slave (
    output h_req_in, h_addr_in, h_we_in, h_wdata_in, m_gnt_in, m_rdata_in,
    input  h_gnt_out, h_rdata_out, h_rvalid_out, m_req_out, m_addr_out, m_we_out, m_wdata_out
  );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one bus host port among Hosts requesters, with burst
// locking of up to MaxBurst accepted beats per ownership and per-host read return.
module bus_host_arbiter #(
  parameter int Hosts        = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int MaxBurst     = 4
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  bus_host_arbiter_if.master                            bif,
  output logic [((Hosts > 1) ? $clog2(Hosts) : 1)-1:0]  owner_out,
  output logic                                          busy_out
);
  localparam int OW = (Hosts > 1) ? $clog2(Hosts) : 1;
  localparam int BW = $clog2(MaxBurst + 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   rd_owner_q, rd_owner_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            rd_pend_q, rd_pend_d;

  logic                    own_req, accept, last_beat;
  logic [OW:0]             pick_idle, pick_next;
  logic [AddressWidth-1:0] sel_addr;
  logic [DataWidth-1:0]    sel_wdata;

  // Returns {found, index}: first requester at or after start (wrapping), skipping excl.
  function automatic logic [OW:0] pick_fn(input logic [Hosts-1:0] req, input int start,
                                          input int excl);
    int          d;
    int          best_d;
    logic [OW:0] r;
    r      = '0;
    best_d = Hosts;
    for (int i = 0; i < Hosts; i++) begin
      d = (i - start + Hosts) % Hosts;
      if (req[i] && (i != excl) && (d < best_d)) begin
        best_d = d;
        r      = {1'b1, OW'(i)};
      end
    end
    return r;
  endfunction

  // Next-state, ownership rotation and the downstream mux.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    beat_cnt_d     = beat_cnt_q;
    rd_pend_d      = 1'b0;
    rd_owner_d     = rd_owner_q;
    sel_addr       = '0;
    sel_wdata      = '0;
    bif.m_req_out  = 1'b0;
    bif.m_we_out   = 1'b0;
    bif.h_gnt_out  = '0;
    own_req        = bif.h_req_in[owner_q];
    accept         = 1'b0;
    last_beat      = 1'b0;
    pick_idle      = pick_fn(bif.h_req_in, int'(rr_ptr_q), -1);
    // After a release the search restarts just past the old owner and skips it.
    pick_next      = pick_fn(bif.h_req_in, (int'(owner_q) + 1) % Hosts, int'(owner_q));
    case (state_q)
      IDLE: begin
        if (pick_idle[OW]) begin
          owner_d    = pick_idle[OW-1:0];
          beat_cnt_d = '0;
          state_d    = OWN;
        end
      end
      OWN: begin
        bif.m_req_out           = own_req;
        bif.m_we_out            = bif.h_we_in[owner_q];
        sel_addr                = bif.h_addr_in[owner_q];
        sel_wdata               = bif.h_wdata_in[owner_q];
        bif.h_gnt_out[owner_q]  = bif.m_gnt_in & own_req;
        accept                  = own_req & bif.m_gnt_in;
        last_beat               = accept && (beat_cnt_q == BW'(MaxBurst - 1));
        beat_cnt_d              = beat_cnt_q + BW'(accept);
        if (accept && !bif.h_we_in[owner_q]) begin
          rd_pend_d  = 1'b1;
          rd_owner_d = owner_q;
        end
        if (!own_req || last_beat) begin
          rr_ptr_d   = OW'((int'(owner_q) + 1) % Hosts);
          beat_cnt_d = '0;
          if (pick_next[OW]) owner_d = pick_next[OW-1:0];
          else if (!own_req) state_d = IDLE;  // burst-limit with no rival keeps the owner
        end
      end
      default: state_d = IDLE;
    endcase
    bif.m_addr_out  = sel_addr;
    bif.m_wdata_out = sel_wdata;
  end

  // Read data returns to whoever issued the read, regardless of current ownership.
  always_comb begin
    bif.h_rvalid_out = '0;
    bif.h_rdata_out  = '0;
    if (rd_pend_q) begin
      bif.h_rvalid_out[rd_owner_q] = 1'b1;
      bif.h_rdata_out[rd_owner_q]  = bif.m_rdata_in;
    end
  end

  // State registers; reset drops any in-flight read response.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign owner_out = owner_q;
  assign busy_out  = (state_q == OWN);
endmodule
